spill_stack_lock_arbiter: RTL and testbench

Arbitrates ownership of the shared spill-stack lock (stack pointer plus stack entries in L1) among N requesters within a tile, e.g. splitter and coalescer.
Grants the lock to exactly one requester at a time, with round-robin fairness and one-hot registered grants.
Tracks hold time and raises a sticky watchdog flag on overlong holds.
Exposes statistics counters for debug readout.

---
 rtl/spill_stack_lock_arbiter.sv | 165 ++++++++++++++++
 tb/tb_spill_stack_lock_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spill_stack_lock_arbiter.sv
// ---------------------------------------------------------------------------
// spill_stack_lock_arbiter
//
// Arbitrates ownership of the shared spill-stack lock (stack pointer plus
// stack entries in L1) among N_REQ requesters in a tile (index 0 = splitter,
// index 1 = coalescer). Exactly one requester owns the lock at a time. The
// arbiter is round-robin with a registered one-hot grant. A sticky watchdog
// flag is raised on overlong holds, and statistics counters are kept for
// debug readout.
//
// Ports:
//   clk          clock
//   rstn         synchronous reset, active-low
//   req          level request per requester, held until grant is seen
//   rel          one-cycle release pulse from the current owner
//                ('release' is a reserved word, so the port is named rel)
//   err_clear    clears timeout_err (a set on the same edge wins)
//   grant        registered one-hot grant, all-zero when the lock is free
//   busy         registered OR of grant
//   owner_id     index of the current owner, 0 when free
//   timeout_err  sticky: hold time reached MAX_HOLD_CYCLES
//   num_grants   total grants issued (wraps)
//   wait_cycles  cycles in which a non-granted requester was waiting (wraps)
//   hold_cnt     cycles the current owner has held the lock (saturating)
// ---------------------------------------------------------------------------
module spill_stack_lock_arbiter #(
    parameter int unsigned N_REQ           = 2,
    parameter int unsigned MAX_HOLD_CYCLES = 4096,
    parameter int unsigned LOG_N_REQ       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     rel,
    input  logic                 err_clear,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic [LOG_N_REQ-1:0] owner_id,
    output logic                 timeout_err,
    output logic [31:0]          num_grants,
    output logic [31:0]          wait_cycles,
    output logic [15:0]          hold_cnt
);

    typedef enum logic {
        FREE = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam logic [15:0] HOLD_LIMIT = 16'(MAX_HOLD_CYCLES - 1);

    state_t               state_q;
    state_t               state_d;
    logic [LOG_N_REQ-1:0] rr_ptr_q;
    logic [LOG_N_REQ-1:0] rr_ptr_d;
    logic [N_REQ-1:0]     grant_d;
    logic [LOG_N_REQ-1:0] owner_d;
    logic [15:0]          hold_d;
    logic                 grant_evt;

    logic                 win_valid;
    logic [LOG_N_REQ-1:0] win_idx;
    logic [LOG_N_REQ-1:0] scan_idx;

    logic                 timeout_set;
    logic                 any_waiting;

    // Round-robin winner: first set req bit scanning upward from rr_ptr,
    // wrapping modulo N_REQ.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = LOG_N_REQ'((32'(rr_ptr_q) + i) % N_REQ);
            if (!win_valid && req[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Next-state and next-output logic. All outputs are registered from
    // these *_d values, so nothing reaches an output combinationally.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        owner_d   = owner_id;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_cnt;
        grant_evt = 1'b0;

        unique case (state_q)
            FREE: begin
                if (win_valid) begin
                    state_d   = HELD;
                    owner_d   = win_idx;
                    hold_d    = '0;
                    grant_evt = 1'b1;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        grant_d[i] = (32'(win_idx) == i);
                    end
                    rr_ptr_d = (win_idx == LOG_N_REQ'(N_REQ - 1)) ? '0
                                                                  : win_idx + LOG_N_REQ'(1);
                end
            end
            HELD: begin
                // Only the owner's release bit matters; releases from other
                // requesters are ignored. The following FREE cycle is the
                // mandatory gap that orders the old owner's last L1 write
                // before the next owner's first read.
                if (rel[owner_id]) begin
                    state_d = FREE;
                    grant_d = '0;
                    owner_d = '0;
                    hold_d  = '0;
                end else if (hold_cnt != 16'hFFFF) begin
                    hold_d = hold_cnt + 16'd1;
                end
            end
        endcase
    end

    assign timeout_set = (state_q == HELD) && (hold_cnt == HOLD_LIMIT);
    assign any_waiting = (req & ~grant) != '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= FREE;
            grant       <= '0;
            busy        <= 1'b0;
            owner_id    <= '0;
            rr_ptr_q    <= '0;
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
            num_grants  <= '0;
            wait_cycles <= '0;
        end else begin
            state_q  <= state_d;
            grant    <= grant_d;
            busy     <= |grant_d;
            owner_id <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            hold_cnt <= hold_d;

            // Set has priority over clear on the same edge.
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end else if (err_clear) begin
                timeout_err <= 1'b0;
            end

            if (grant_evt) begin
                num_grants <= num_grants + 32'd1;
            end
            if (any_waiting) begin
                wait_cycles <= wait_cycles + 32'd1;
            end
        end
    end

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rstn) $onehot0(grant));
    a_busy_matches  : assert property (@(posedge clk) disable iff (!rstn) busy == (grant != '0));

endmodule

// File: tb/tb_spill_stack_lock_arbiter.sv
module tb_spill_stack_lock_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Two-requester DUT with a short watchdog threshold.
    logic        rstn;
    logic [1:0]  req;
    logic [1:0]  rel;
    logic        err_clear;
    logic [1:0]  grant;
    logic        busy;
    logic        owner_id;
    logic        timeout_err;
    logic [31:0] num_grants;
    logic [31:0] wait_cycles;
    logic [15:0] hold_cnt;

    spill_stack_lock_arbiter #(
        .N_REQ           (2),
        .MAX_HOLD_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .rel         (rel),
        .err_clear   (err_clear),
        .grant       (grant),
        .busy        (busy),
        .owner_id    (owner_id),
        .timeout_err (timeout_err),
        .num_grants  (num_grants),
        .wait_cycles (wait_cycles),
        .hold_cnt    (hold_cnt)
    );

    // Four-requester DUT for the random stress phase.
    logic        s_rstn;
    logic [3:0]  s_req;
    logic [3:0]  s_rel;
    logic        s_clr;
    logic [3:0]  s_grant;
    logic        s_busy;
    logic [1:0]  s_owner;
    logic        s_tmo;
    logic [31:0] s_ng;
    logic [31:0] s_wc;
    logic [15:0] s_hold;

    spill_stack_lock_arbiter #(
        .N_REQ (4)
    ) dut4 (
        .clk         (clk),
        .rstn        (s_rstn),
        .req         (s_req),
        .rel         (s_rel),
        .err_clear   (s_clr),
        .grant       (s_grant),
        .busy        (s_busy),
        .owner_id    (s_owner),
        .timeout_err (s_tmo),
        .num_grants  (s_ng),
        .wait_cycles (s_wc),
        .hold_cnt    (s_hold)
    );

    typedef struct {
        logic        rstn;
        logic [1:0]  req;
        logic [1:0]  rel;
        logic        clr;
        logic [1:0]  grant;
        logic        owner;
        logic        busy;
        logic        tmo;
        logic [15:0] hold;
        logic [31:0] ng;
        logic [31:0] wc;
    } vec_t;

    vec_t vecs [22];

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] g, input logic o,
                             input logic b, input logic t, input logic [15:0] h,
                             input logic [31:0] ng, input logic [31:0] wc);
        chk({tag, "_grant"},   32'(grant),       32'(g));
        chk({tag, "_owner"},   32'(owner_id),    32'(o));
        chk({tag, "_busy"},    32'(busy),        32'(b));
        chk({tag, "_timeout"}, 32'(timeout_err), 32'(t));
        chk({tag, "_hold"},    32'(hold_cnt),    32'(h));
        chk({tag, "_ngrants"}, num_grants,       ng);
        chk({tag, "_wait"},    wait_cycles,      wc);
    endtask

    initial begin
        logic [3:0]  prev_g;
        logic [3:0]  req_v;
        logic [3:0]  rel_v;
        int unsigned edges;
        int unsigned skipped [4];
        bit          waiting [4];
        int unsigned hold_left;

        rstn = 1'b0; req = '0; rel = '0; err_clear = 1'b0;
        s_rstn = 1'b0; s_req = '0; s_rel = '0; s_clr = 1'b0;

        //            rstn req    rel    clr | grant  own  busy tmo hold    ngr    wait
        vecs[0]  = '{1'b1, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'd0, 32'd1, 32'd1};
        vecs[1]  = '{1'b1, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'd1, 32'd1, 32'd1};
        vecs[2]  = '{1'b1, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'd2, 32'd1, 32'd1};
        vecs[3]  = '{1'b1, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'd3, 32'd1, 32'd1};
        vecs[4]  = '{1'b1, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'd4, 32'd1, 32'd1};
        vecs[5]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 32'd1, 32'd1};
        vecs[6]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 32'd1, 32'd1};
        vecs[7]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0};
        vecs[8]  = '{1'b1, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'd0, 32'd1, 32'd1};
        vecs[9]  = '{1'b1, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'd1, 32'd1, 32'd2};
        vecs[10] = '{1'b1, 2'b11, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 32'd1, 32'd3};
        vecs[11] = '{1'b1, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 16'd0, 32'd2, 32'd4};
        vecs[12] = '{1'b1, 2'b10, 2'b01, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 16'd1, 32'd2, 32'd4};
        vecs[13] = '{1'b1, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 32'd2, 32'd4};
        vecs[14] = '{1'b1, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'd0, 32'd3, 32'd5};
        vecs[15] = '{1'b1, 2'b11, 2'b10, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'd1, 32'd3, 32'd6};
        vecs[16] = '{1'b1, 2'b11, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 32'd3, 32'd7};
        vecs[17] = '{1'b1, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 16'd0, 32'd4, 32'd8};
        vecs[18] = '{1'b1, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 32'd4, 32'd8};
        vecs[19] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 32'd4, 32'd8};
        vecs[20] = '{1'b1, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 32'd4, 32'd8};
        vecs[21] = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 32'd4, 32'd8};

        // Reset state.
        tick();
        tick();
        chk_state("reset", 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0);

        // Basic grant/release, alternation, non-owner release, release while free.
        for (int i = 0; i < 22; i++) begin
            rstn = vecs[i].rstn; req = vecs[i].req; rel = vecs[i].rel; err_clear = vecs[i].clr;
            tick();
            chk_state($sformatf("v%0d", i), vecs[i].grant, vecs[i].owner, vecs[i].busy,
                      vecs[i].tmo, vecs[i].hold, vecs[i].ng, vecs[i].wc);
        end
        rstn = 1'b1; req = '0; rel = '0; err_clear = 1'b0;

        // Watchdog: hold without release (rr_ptr = 0 here).
        req = 2'b01;
        tick();
        chk("wd_grant", 32'(grant), 32'h1);
        chk("wd_ngrants", num_grants, 32'd5);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("wd_hold%0d", k), 32'(hold_cnt), 32'(k));
        end
        chk("wd_tmo_before", 32'(timeout_err), 32'h0);
        tick();
        chk("wd_tmo_set", 32'(timeout_err), 32'h1);
        chk("wd_hold8", 32'(hold_cnt), 32'd8);
        rel = 2'b01;
        tick();
        rel = 2'b00; req = 2'b00;
        chk("wd_released", 32'(grant), 32'h0);
        chk("wd_tmo_sticky", 32'(timeout_err), 32'h1);
        tick();
        chk("wd_tmo_sticky2", 32'(timeout_err), 32'h1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("wd_tmo_cleared", 32'(timeout_err), 32'h0);

        // Set and clear on the same edge: set wins (rr_ptr = 1, only req[0]).
        req = 2'b01;
        tick();
        chk("sc_grant", 32'(grant), 32'h1);
        chk("sc_ngrants", num_grants, 32'd6);
        for (int k = 1; k <= 7; k++) tick();
        chk("sc_hold7", 32'(hold_cnt), 32'd7);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("sc_set_wins", 32'(timeout_err), 32'h1);
        tick();
        chk("sc_still_set", 32'(timeout_err), 32'h1);
        rel = 2'b01;
        tick();
        rel = 2'b00; req = 2'b00;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("sc_cleared", 32'(timeout_err), 32'h0);

        // Reset mid-hold (rr_ptr = 1, so req[1] wins).
        req = 2'b10;
        tick();
        chk("rh_grant", 32'(grant), 32'h2);
        chk("rh_owner", 32'(owner_id), 32'h1);
        for (int k = 1; k <= 100; k++) tick();
        chk("rh_hold100", 32'(hold_cnt), 32'd100);
        rstn = 1'b0;
        tick();
        chk_state("rh_reset", 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0);
        rstn = 1'b1; req = 2'b11;
        tick();
        chk("rh_rrptr0", 32'(grant), 32'h1);
        rel = 2'b01; req = 2'b00;
        tick();
        rel = 2'b00;

        // Random stress on the four-requester instance.
        edges = 0;
        hold_left = 0;
        prev_g = '0;
        for (int i = 0; i < 4; i++) begin
            skipped[i] = 0;
            waiting[i] = 1'b0;
        end
        tick();
        s_rstn = 1'b1;
        tick();
        for (int c = 0; c < 10000; c++) begin
            chk("stress_onehot0", 32'($onehot0(s_grant)), 32'h1);
            for (int j = 0; j < 4; j++) begin
                if (s_grant[j] && !prev_g[j]) begin
                    edges++;
                    chk($sformatf("stress_starve_r%0d", j), 32'(skipped[j] <= 3), 32'h1);
                    skipped[j] = 0;
                    waiting[j] = 1'b0;
                    hold_left = $urandom_range(0, 5);
                    for (int i = 0; i < 4; i++) begin
                        if (i != j && waiting[i]) skipped[i]++;
                    end
                end
            end
            req_v = s_req;
            rel_v = '0;
            if (s_grant != '0) begin
                if (hold_left == 0) begin
                    rel_v = s_grant;
                    if ($urandom_range(0, 1) == 0) begin
                        req_v = req_v & ~s_grant;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            if (s_grant[i]) begin
                                waiting[i] = 1'b1;
                                skipped[i] = 0;
                            end
                        end
                    end
                end else begin
                    hold_left--;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!req_v[i] && $urandom_range(0, 2) == 0) begin
                    req_v[i] = 1'b1;
                    waiting[i] = 1'b1;
                    skipped[i] = 0;
                end
                if (!s_grant[i] && $urandom_range(0, 7) == 0) rel_v[i] = 1'b1;
            end
            prev_g = s_grant;
            s_req = req_v;
            s_rel = rel_v;
            tick();
        end
        edges += $countones(s_grant & ~prev_g);
        chk("stress_num_grants", s_ng, 32'(edges));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
